// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths and requester indices for the port B arbiter
package mem_port_arbiter_pkg;

    // Unified memory geometry (64K x 16)
    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    // Requester slots on port B
    localparam int REQ_VGA = 0;
    localparam int REQ_DMA = 1;
    localparam int REQ_DBG = 2;

    // Starvation counter width; covers STARVE_LIMIT up to 255
    localparam int STARVE_W = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rtl/mem_port_arbiter_rr_picker.sv - combinational round-robin picker with optional skip of index 0
//
// Ports:
//   req   - request mask, one bit per requester
//   ptr   - index of the last round-robin winner; search starts at ptr+1
//   skip0 - ignore index 0 unless it is the only requester
//   gnt   - one-hot grant, all zero when req is empty
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               skip0,
    output logic [NUM_REQ-1:0] gnt
);

    logic [NUM_REQ-1:0] eff;
    logic               found;

    always_comb begin
        eff = req;
        if (skip0 && (|req[NUM_REQ-1:1])) begin
            eff[0] = 1'b0;
        end

        gnt   = '0;
        found = 1'b0;
        // Walk offsets 1..NUM_REQ from the pointer; the first set bit wins.
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && eff[k] && (k == ((int'(ptr) + off) % NUM_REQ))) begin
                    gnt[k] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares memory port B among NUM_REQ requesters, one access per cycle
//
// Ports:
//   clock, reset                  - system clock, synchronous active-low reset
//   req_valid/req_write           - per-requester request and direction
//   req_address/req_write_data    - packed payloads, requester i at [16i+15:16i]
//   req_ready                     - one-hot combinational grant
//   rsp_valid/rsp_data            - one-hot response tag and data, one cycle after issue
//   mem_address/mem_write_data/
//   mem_write_enable/mem_read_data - registered port B interface (memory samples on negedge)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int PRIORITY0    = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [MEM_ADDR_W*NUM_REQ-1:0]    req_address,
    input  logic [MEM_DATA_W*NUM_REQ-1:0]    req_write_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [MEM_DATA_W-1:0]            rsp_data,
    output logic [MEM_ADDR_W-1:0]            mem_address,
    output logic [MEM_DATA_W-1:0]            mem_write_data,
    output logic                             mem_write_enable,
    input  logic [MEM_DATA_W-1:0]            mem_read_data
);

    localparam int                   PTR_W = $clog2(NUM_REQ);
    localparam logic [STARVE_W-1:0]  LIMIT = STARVE_W'(STARVE_LIMIT);
    localparam logic [NUM_REQ-1:0]   ONE   = NUM_REQ'(1);
    localparam logic                 PRIO  = (PRIORITY0 != 0);

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       pend_id;
    logic                   pend_valid;
    logic [STARVE_W-1:0]    starve_cnt;
    logic [STARVE_W-1:0]    starve_next;

    logic [NUM_REQ-1:0]     rr_gnt;
    logic [NUM_REQ-1:0]     gnt;
    logic [PTR_W-1:0]       gnt_idx;
    logic                   any_gnt;
    logic                   others_valid;
    logic                   mask0;
    logic                   prio_win;
    logic [MEM_ADDR_W-1:0]  sel_addr;
    logic [MEM_DATA_W-1:0]  sel_data;
    logic                   sel_write;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .skip0 (PRIO),
        .gnt   (rr_gnt)
    );

    always_comb begin
        others_valid = |req_valid[NUM_REQ-1:1];
        mask0        = PRIO && (starve_cnt == LIMIT);
        prio_win     = PRIO && req_valid[0] && !mask0;
        gnt          = prio_win ? ONE : rr_gnt;
        any_gnt      = |gnt;

        gnt_idx   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx   = PTR_W'(i);
                sel_addr  = req_address[MEM_ADDR_W*i +: MEM_ADDR_W];
                sel_data  = req_write_data[MEM_DATA_W*i +: MEM_DATA_W];
                sel_write = req_write[i];
            end
        end

        // Counts requester-0 wins only while someone else is waiting; saturates at the limit.
        if (!PRIO || !others_valid) begin
            starve_next = '0;
        end else if (gnt[0]) begin
            starve_next = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + STARVE_W'(1);
        end else begin
            starve_next = '0;
        end
    end

    assign req_ready = reset ? gnt : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            rsp_valid        <= '0;
            rsp_data         <= '0;
            rr_ptr           <= PTR_W'(NUM_REQ - 1);
            starve_cnt       <= '0;
            pend_valid       <= 1'b0;
            pend_id          <= '0;
        end else begin
            if (any_gnt) begin
                mem_address      <= sel_addr;
                mem_write_data   <= sel_data;
                mem_write_enable <= sel_write;
                pend_valid       <= 1'b1;
                pend_id          <= gnt_idx;
                // Fixed-priority wins leave the rotation untouched.
                if (!prio_win) begin
                    rr_ptr <= gnt_idx;
                end
            end else begin
                mem_write_enable <= 1'b0;
                pend_valid       <= 1'b0;
            end

            // Memory drove read_data on the negedge of the issue cycle.
            if (pend_valid) begin
                rsp_data  <= mem_read_data;
                rsp_valid <= ONE << pend_id;
            end else begin
                rsp_valid <= '0;
            end

            starve_cnt <= starve_next;
        end
    end

endmodule
